// File: rtl/exp_sched_pkg.sv
// Shared types and constants for the exp stream scheduler.
package exp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3f80_0000;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that delays a valid vector by DEPTH cycles; DEPTH must be >= 2.
module valid_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                        Clock,
  input  logic                        Clear,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] vld_pipe
);

  always_ff @(posedge Clock) begin
    if (Clear) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[DEPTH-2:0], din};
  end

endmodule

// File: rtl/exp_stream_scheduler.sv
// Streams Len operands from the input buffer through the pipelined exp unit
// and writes each result back at the matching index.
module exp_stream_scheduler
  import exp_sched_pkg::*;
#(
  parameter int BITWIDTH    = 32,
  parameter int ADDRW       = 8,
  parameter int EXP_LATENCY = 141
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [ADDRW:0]      Len,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic                RdEn,
  output logic [ADDRW-1:0]    RdAddr,
  input  logic [BITWIDTH-1:0] RdData,
  output logic                WrEn,
  output logic [ADDRW-1:0]    WrAddr,
  output logic [BITWIDTH-1:0] WrData,
  output logic                ExpStr,
  output logic [BITWIDTH-1:0] ExpDatain,
  input  logic                ExpAck,
  input  logic [BITWIDTH-1:0] ExpDataOut
);

  localparam logic [ADDRW:0] CNT_ONE = {{ADDRW{1'b0}}, 1'b1};

  state_t                           state, state_nx;
  logic [ADDRW:0]                   len_q, iss_cnt, wr_cnt;
  logic                             in_vld, tap, last_wr, accept;
  logic [EXP_LATENCY-1:0][0:0]      vld_pipe;

  valid_delay_line #(.DEPTH(EXP_LATENCY), .WIDTH(1)) u_vld_dly (
    .Clock    (Clock),
    .Clear    (Reset),
    .din      (in_vld),
    .vld_pipe (vld_pipe)
  );

  assign tap     = vld_pipe[EXP_LATENCY-1][0];
  // Done is registered, so the FSM is already IDLE during the Done cycle;
  // holding off Start there keeps the next run from overlapping it.
  assign accept  = (state == IDLE) && Start && !Done;
  assign last_wr = tap && (wr_cnt == len_q - CNT_ONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (Len == '0) ? FINISH : ISSUE;
      ISSUE:   if (iss_cnt == len_q - CNT_ONE) state_nx = DRAIN;
      DRAIN:   if (last_wr) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      len_q   <= '0;
      iss_cnt <= '0;
      wr_cnt  <= '0;
      in_vld  <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state  <= state_nx;
      in_vld <= (state == ISSUE);
      Done   <= (state == FINISH);
      if (accept) begin
        len_q   <= Len;
        iss_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (state == ISSUE) iss_cnt <= iss_cnt + CNT_ONE;
        if (tap)            wr_cnt  <= wr_cnt + CNT_ONE;
      end
      if (tap && !ExpAck) Err <= 1'b1;
    end
  end

  assign Busy      = (state != IDLE) || Done;
  assign RdEn      = (state == ISSUE);
  assign RdAddr    = RdEn ? iss_cnt[ADDRW-1:0] : '0;
  // Str spans first operand through the last capture, bubbles included.
  assign ExpStr    = in_vld || (|vld_pipe);
  assign ExpDatain = in_vld ? RdData : BITWIDTH'(FP_ZERO);
  assign WrEn      = tap;
  assign WrAddr    = tap ? wr_cnt[ADDRW-1:0] : '0;
  assign WrData    = tap ? ExpDataOut : '0;

endmodule
